shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 28 ++
 rtl/shift_sub_divider.sv | 100 ++++++++++
 tb/tb_shift_sub_divider.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the shift/subtract divider.
package div_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] next_rem,
    output logic [N-1:0] next_quo
);

    logic [N:0]   shifted;
    logic [N-1:0] diff;
    logic         borrow;

    // Working remainder stays below divisor, so the shifted value fits N+1 bits and
    // any non-borrowing difference fits back into N bits.
    always_comb begin
        shifted  = {rem, quo[N-1]};
        borrow   = shifted < {1'b0, divisor};
        diff     = shifted[N-1:0] - divisor;
        next_rem = borrow ? shifted[N-1:0] : diff;
        next_quo = {quo[N-2:0], ~borrow};
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Multi-cycle unsigned divider: IDLE -> RUN (N steps) -> DONE, results registered
// and presented with a one-cycle done pulse on the edge that leaves DONE.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [N-1:0]  rem_w;
    logic [N-1:0]  quo_w;
    logic [N-1:0]  div_w;
    logic          zero_w;
    logic [N-1:0]  step_rem;
    logic [N-1:0]  step_quo;

    div_step #(.N(N)) u_step (
        .rem      (rem_w),
        .quo      (quo_w),
        .divisor  (div_w),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
            RUN:  if (count == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // For a zero divisor no steps run, so quo_w still holds the captured dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rem_w       <= '0;
            quo_w       <= '0;
            div_w       <= '0;
            zero_w      <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= '0;
                        rem_w  <= '0;
                        quo_w  <= dividend;
                        div_w  <= divisor;
                        zero_w <= (divisor == '0);
                    end
                end
                RUN: begin
                    rem_w <= step_rem;
                    quo_w <= step_quo;
                    count <= count + 1'b1;
                end
                DONE: begin
                    done        <= 1'b1;
                    quotient    <= zero_w ? '1 : quo_w;
                    remainder   <= zero_w ? quo_w : rem_w;
                    div_by_zero <= zero_w;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: drivers push expected results, a negedge
// monitor pops and checks value and arrival cycle whenever done is seen.
module tb_shift_sub_divider;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    shift_sub_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // cyc at a negedge is the index of the most recent rising edge.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("quotient", 32'(quotient), 32'(e.q));
                check_output("remainder", 32'(remainder), 32'(e.r));
                check_output("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                check_output("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Presents operands with start high and waits for the accepting edge;
    // with hold set, start stays high so the next call runs back-to-back.
    task automatic apply_stimulus(input logic [N-1:0] dd, input logic [N-1:0] dv, input bit hold);
        exp_t e;
        bit   ok;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got ready=0 for 100 cycles, expected ready=1");
        end
        e.q   = (dv == 0) ? {N{1'b1}} : dd / dv;
        e.r   = (dv == 0) ? dd : dd % dv;
        e.dz  = (dv == 0);
        e.cyc = cyc + 1 + ((dv == 0) ? 1 : N + 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rd;
        logic [N-1:0] rv;

        #12;
        check_output("reset_ready", 32'(ready), 32'd1);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_quotient", 32'(quotient), 32'd0);
        check_output("reset_remainder", 32'(remainder), 32'd0);
        check_output("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(16'd100, 16'd7, 1'b0);
        wait_drain();
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0);
        wait_drain();
        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0);
        wait_drain();
        apply_stimulus(16'h0005, 16'h0000, 1'b0);
        wait_drain();

        // Second request arrives mid-RUN and must be dropped; old results must hold.
        apply_stimulus(16'd3, 16'd10, 1'b0);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("busy_ready", 32'(ready), 32'd0);
        check_output("hold_quotient", 32'(quotient), 32'hFFFF);
        check_output("hold_remainder", 32'(remainder), 32'h0005);
        check_output("hold_dbz", 32'(div_by_zero), 32'd1);
        start = 1'b0;
        wait_drain();
        repeat (N + 4) @(posedge clk);
        #1;

        // Reset during RUN cycle 5 abandons the division.
        apply_stimulus(16'd100, 16'd7, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_output("midrst_ready", 32'(ready), 32'd1);
        check_output("midrst_done", 32'(done), 32'd0);
        check_output("midrst_quotient", 32'(quotient), 32'd0);
        check_output("midrst_remainder", 32'(remainder), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        apply_stimulus(16'd81, 16'd9, 1'b0);
        wait_drain();

        // Back-to-back random operands with start held high.
        for (int i = 0; i < 1000; i++) begin
            rd = N'($urandom);
            rv = (i % 10 == 3) ? '0 : N'($urandom_range(0, (i % 2) ? 65535 : 255));
            apply_stimulus(rd, rv, 1'b1);
        end
        start = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
